// File: rtl/cost_table_if.sv
// Load-stream bundle for the cost table: a 7-bit cost per beat with valid/ready flow control.
// The producer drives valid/data through master; the table drives ready through slave.
interface cost_table_if;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/cost_table.sv
// 8x8 worker/job cost store, loaded row-major over a valid/ready stream, with a
// running sum of per-row minima used by the assignment engine as a lower bound.
module cost_table (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Clear,
    cost_table_if.slave  ld,
    input  logic [2:0]   W,
    input  logic [2:0]   J,
    output logic [6:0]   Cost,
    output logic         Ready,
    output logic [9:0]   LowerBound
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t     state_reg;
    logic [5:0] idx_reg;
    logic [6:0] rmin_reg;
    logic [9:0] acc_reg;
    logic       ready_reg;
    logic [6:0] mem_reg [64];

    logic       accept;
    logic [6:0] row_min_next;

    // Ready must not depend on in_valid, so it is purely state and Clear.
    assign ld.in_ready = (state_reg == ST_LOAD) && !Clear;
    assign accept      = ld.in_valid && ld.in_ready;

    always_comb begin
        row_min_next = rmin_reg;
        if (ld.in_data < rmin_reg) begin
            row_min_next = ld.in_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_LOAD;
            idx_reg   <= 6'd0;
            rmin_reg  <= 7'd0;
            acc_reg   <= 10'd0;
            ready_reg <= 1'b0;
        end else if (Clear) begin
            state_reg <= ST_LOAD;
            idx_reg   <= 6'd0;
            rmin_reg  <= 7'd0;
            acc_reg   <= 10'd0;
            ready_reg <= 1'b0;
        end else if (accept) begin
            idx_reg <= idx_reg + 6'd1;
            // First beat of a row seeds the minimum; later beats fold into it.
            if (idx_reg[2:0] == 3'd0) begin
                rmin_reg <= ld.in_data;
            end else begin
                rmin_reg <= row_min_next;
            end
            if (idx_reg[2:0] == 3'd7) begin
                acc_reg <= acc_reg + {3'b000, row_min_next};
            end
            if (idx_reg == 6'd63) begin
                state_reg <= ST_DONE;
                ready_reg <= 1'b1;
            end
        end
    end

    // Clear leaves the table intact; only reset wipes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 64; i++) begin
                mem_reg[i] <= 7'd0;
            end
        end else if (accept) begin
            mem_reg[idx_reg] <= ld.in_data;
        end
    end

    assign Cost       = mem_reg[{W, J}];
    assign Ready      = ready_reg;
    assign LowerBound = acc_reg;

endmodule

// File: tb/tb_cost_table.sv
// Randomized bench for cost_table: a table-level model (written entries, beat count,
// row minima summed over completed rows) is compared against the DUT every cycle.
module tb_cost_table;

    logic       CLK;
    logic       RST;
    logic       Clear;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       Ready;
    logic [9:0] LowerBound;

    cost_table_if ld_if ();

    cost_table dut (
        .CLK        (CLK),
        .RST        (RST),
        .Clear      (Clear),
        .ld         (ld_if.slave),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .Ready      (Ready),
        .LowerBound (LowerBound)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int  m_mem [64];
    int  m_cnt;
    bit  m_ready;
    bit  check_en;
    int  n_total;
    int  n_pass;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Sum of minima of every row fully loaded since the last restart.
    function automatic int model_lb();
        int s;
        s = 0;
        for (int r = 0; r < m_cnt / 8; r++) begin
            int mn;
            mn = 127;
            for (int j = 0; j < 8; j++) begin
                if (m_mem[r * 8 + j] < mn) mn = m_mem[r * 8 + j];
            end
            s += mn;
        end
        return s;
    endfunction

    // One clock: apply inputs, take the edge, then advance the model with what was applied.
    task automatic step(input bit v, input int d, input bit clr, input bit rst, input int wj);
        ld_if.in_valid = v;
        ld_if.in_data  = 7'(d);
        Clear          = clr;
        RST            = rst;
        if (wj < 0) begin
            W = 3'($urandom_range(7));
            J = 3'($urandom_range(7));
        end else begin
            W = 3'(wj / 8);
            J = 3'(wj % 8);
        end
        @(posedge CLK);
        #1;
        if (rst) begin
            for (int i = 0; i < 64; i++) m_mem[i] = 0;
            m_cnt   = 0;
            m_ready = 1'b0;
        end else if (clr) begin
            m_cnt   = 0;
            m_ready = 1'b0;
        end else if (v && !m_ready) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 64) m_ready = 1'b1;
        end
        $display("cycle t=%0t valid=%0d data=%0d clear=%0d rst=%0d cnt=%0d ready=%0d lb=%0d",
                 $time, v, d, clr, rst, m_cnt, Ready, LowerBound);
    endtask

    task automatic idle(input int wj);
        step(1'b0, 0, 1'b0, 1'b0, wj);
    endtask

    task automatic sweep();
        for (int i = 0; i < 64; i++) idle(i);
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            check("ready", int'(Ready), int'(m_ready));
            check("lower_bound", int'(LowerBound), model_lb());
            check("in_ready", int'(ld_if.in_ready), int'(!m_ready && !Clear));
            check("cost", int'(Cost), m_mem[{W, J}]);
        end
    end

    initial begin
        int guard;
        n_total  = 0;
        n_pass   = 0;
        check_en = 1'b0;
        m_cnt    = 0;
        m_ready  = 1'b0;
        for (int i = 0; i < 64; i++) m_mem[i] = 0;

        // Reset then read every entry.
        step(1'b0, 0, 1'b0, 1'b1, 0);
        check_en = 1'b1;
        check("reset_lb", int'(LowerBound), 0);
        check("reset_ready", int'(Ready), 0);
        sweep();

        // Back-to-back load of k mod 100.
        for (int k = 0; k < 64; k++) begin
            step(1'b1, k % 100, 1'b0, 1'b0, -1);
            if (k == 62) check("ready_before_last", int'(Ready), 0);
        end
        check("ramp_lb", int'(LowerBound), 224);
        check("ramp_ready", int'(Ready), 1);
        sweep();

        // All 127 with random bubbles, starting from a Clear in DONE.
        step(1'b0, 0, 1'b1, 1'b0, -1);
        guard = 0;
        while (m_cnt < 64 && guard < 1000) begin
            step(1'($urandom_range(1)), 127, 1'b0, 1'b0, -1);
            guard++;
        end
        check("bubble_load_done", int'(m_cnt == 64), 1);
        check("max_lb", int'(LowerBound), 1016);

        // Row 2 minimum arrives on its last beat.
        step(1'b0, 0, 1'b1, 1'b0, -1);
        for (int k = 0; k < 64; k++) begin
            step(1'b1, (k / 8 == 2) ? ((k % 8 == 7) ? 3 : 9) : 50, 1'b0, 1'b0, -1);
        end
        check("row_edge_lb", int'(LowerBound), 353);

        // Clear mid-load with a beat presented, then a full reload of ones.
        step(1'b0, 0, 1'b1, 1'b0, -1);
        for (int k = 0; k < 20; k++) step(1'b1, $urandom_range(127), 1'b0, 1'b0, -1);
        step(1'b1, 99, 1'b1, 1'b0, 20);
        check("clear_lb", int'(LowerBound), 0);
        for (int k = 0; k < 64; k++) step(1'b1, 1, 1'b0, 1'b0, -1);
        check("ones_lb", int'(LowerBound), 8);
        sweep();

        // Beats after DONE are ignored.
        for (int k = 0; k < 10; k++) step(1'b1, 0, 1'b0, 1'b0, k * 6);
        check("post_done_lb", int'(LowerBound), 8);
        check("post_done_ready", int'(Ready), 1);
        check("post_done_cost", int'(Cost), 1);

        // Reset on the cycle of beat 63 wins.
        step(1'b0, 0, 1'b1, 1'b0, -1);
        for (int k = 0; k < 63; k++) step(1'b1, $urandom_range(127), 1'b0, 1'b0, -1);
        step(1'b1, 5, 1'b0, 1'b1, -1);
        check("rst_last_ready", int'(Ready), 0);
        check("rst_last_lb", int'(LowerBound), 0);
        sweep();

        // Random loads with bubbles and occasional mid-load Clear.
        for (int round = 0; round < 4; round++) begin
            step(1'b0, 0, 1'b1, 1'b0, -1);
            guard = 0;
            while (!m_ready && guard < 300) begin
                step(1'($urandom_range(3) != 0), $urandom_range(127),
                     1'($urandom_range(60) == 0), 1'b0, -1);
                guard++;
            end
            for (int k = 0; k < 5; k++) step(1'($urandom_range(1)), $urandom_range(127), 1'b0, 1'b0, -1);
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
